mux16_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for a shared 16:1 word mux (mux16). Up to 16

---
 rtl/mux16_rr_arbiter_pkg.sv | 19 +
 rtl/mux16_rr_arbiter_if.sv | 23 ++
 rtl/mux16_rr_arbiter_rr_pick16.sv | 33 +++
 rtl/mux16_rr_arbiter.sv | 98 +++++++++
 tb/tb_mux16_rr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux16_rr_arbiter_pkg.sv
// mux16_rr_arbiter_pkg: shared types for the 16-way round-robin arbiter.
// Holds the mux select / request vector types, the arbiter state enum and
// a one-hot decode helper used when loading the grant register.
package mux16_rr_arbiter_pkg;

  typedef logic [3:0]  lc3b_mux16_sel;
  typedef logic [15:0] lc3b_req16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } lc3b_arb_state;

  // Decode a select index into the matching one-hot grant vector.
  function automatic lc3b_req16 onehot16(input lc3b_mux16_sel idx);
    return lc3b_req16'(1) << idx;
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// mux16_rr_arbiter_if: request/grant bundle between the requesting units
// (master side) and the arbiter (slave side). clk and reset_n stay outside.
interface mux16_rr_arbiter_if;
  import mux16_rr_arbiter_pkg::*;

  lc3b_req16     req;
  logic          done;
  lc3b_req16     grant;
  lc3b_mux16_sel sel;
  logic          busy;
  logic          timeout_err;

  modport master (
    output req, done,
    input  grant, sel, busy, timeout_err
  );

  modport slave (
    input  req, done,
    output grant, sel, busy, timeout_err
  );

endinterface

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// rr_pick16: combinational round-robin picker. Returns the first set request
// at ptr, ptr+1, ... wrapping mod 16, plus a flag that any request is set.
module rr_pick16
  import mux16_rr_arbiter_pkg::*;
(
  input  lc3b_req16     req,
  input  lc3b_mux16_sel ptr,
  output lc3b_mux16_sel win,
  output logic          any
);

  // req rotated so that bit 0 is the requester currently holding top priority
  lc3b_req16 rot;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
      assign rot[gi] = req[ptr + 4'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector wins; scan downward so the last hit is the lowest.
  always_comb begin
    win = ptr;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) begin
        win = ptr + 4'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter driving the select of a shared 16:1
// word mux. Grants one requester, holds the grant until done, then rotates
// priority to the requester after the winner.
// Optional feature macro: ARB_TIMEOUT_EN adds a grant timer that forces a
// release after TIMEOUT_CYCLES cycles and pulses timeout_err.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic                clk,
  input  logic                reset_n,
  mux16_rr_arbiter_if.slave   bus
);

  lc3b_arb_state state_reg;
  lc3b_req16     grant_reg;
  lc3b_mux16_sel sel_reg;
  lc3b_mux16_sel ptr_reg;
  logic          busy_reg;
  logic          terr_reg;

  lc3b_mux16_sel win;
  logic          any;
  logic          timeout_hit;

  rr_pick16 u_pick (
    .req (bus.req),
    .ptr (ptr_reg),
    .win (win),
    .any (any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] timer_reg;

  // Last allowed grant cycle: the timer counts 0..TIMEOUT_CYCLES-1.
  assign timeout_hit = (timer_reg == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Arbiter FSM with registered grant/sel/busy/timeout_err outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      sel_reg   <= '0;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
      terr_reg  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timer_reg <= '0;
`endif
    end else begin
      terr_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          // sel keeps the last winner while idle so the mux output stays stable
          if (any) begin
            state_reg <= ARB_GRANT;
            grant_reg <= onehot16(win);
            sel_reg   <= win;
            busy_reg  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            timer_reg <= '0;
`endif
          end
        end
        ARB_GRANT: begin
          // req is ignored here; only done (or the timer) ends ownership
          if (bus.done || timeout_hit) begin
            state_reg <= ARB_IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            ptr_reg   <= sel_reg + 4'd1;
            terr_reg  <= timeout_hit & ~bus.done;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            timer_reg <= timer_reg + 8'd1;
          end
`endif
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.sel         = sel_reg;
  assign bus.busy        = busy_reg;
  assign bus.timeout_err = terr_reg;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a behavioural arbiter model.
module tb_mux16_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TMO    = 4;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TMO    = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // behavioural model: owner index, rotation pointer, cycles spent in grant
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_held;
  bit m_terr;

  mux16_rr_arbiter_if bus ();

`ifdef ARB_TIMEOUT_EN
  mux16_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
  mux16_rr_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_terr = 0;
  endtask

  task automatic model_edge(input logic [15:0] r, input logic d);
    bit forced;
    m_terr = 0;
    if (!m_busy) begin
      if (r != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          int idx;
          idx = (m_ptr + k) % 16;
          if (r[idx]) begin
            m_sel = idx;
            break;
          end
        end
        m_busy = 1;
        m_held = 0;
      end
    end else begin
      m_held++;
      forced = TMO_EN && (m_held >= TMO) && !d;
      if (d || forced) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 16;
        m_terr = forced;
      end
    end
  endtask

  function automatic logic [21:0] model_out();
    logic [15:0] g;
    g = m_busy ? 16'(32'd1 << m_sel) : 16'h0;
    return {g, 4'(m_sel), m_busy, m_terr};
  endfunction

  function automatic logic [21:0] cur_obs();
    return {bus.grant, bus.sel, bus.busy, bus.timeout_err};
  endfunction

  // one clock edge: inputs are already stable, model follows the edge, sample on negedge
  task automatic cyc();
    @(posedge clk);
    model_edge(bus.req, bus.done);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    bus.req  = 16'h0;
    bus.done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    bus.req  = 16'hFFFF;
    bus.done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (cur_obs() !== 22'h0) begin
      n_errors++; $display("FAIL reset_state: got %h expected %h", cur_obs(), 22'h0);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus.grant !== 16'h0) begin
      n_errors++; $display("FAIL reset_release_grant: got %h expected 0000", bus.grant);
    end
    cyc();
    n_checks++;
    if (cur_obs() !== model_out() || bus.grant !== 16'h0001 || bus.sel !== 4'd0) begin
      n_errors++; $display("FAIL reset_first_grant: got %h expected %h", cur_obs(), model_out());
    end
    cyc();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.grant !== 16'h0 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_async_mid_grant: grant %h busy %b expected 0000 0", bus.grant, bus.busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_rotation();
    do_reset();
    bus.req = 16'hFFFF;
    for (int g = 0; g < 17; g++) begin
      bus.done = 1'b0;
      cyc();
      n_checks++;
      if (cur_obs() !== model_out() || bus.sel !== 4'(g % 16) || bus.busy !== 1'b1) begin
        n_errors++; $display("FAIL rotation_grant_%0d: got %h expected %h sel %0d", g, cur_obs(), model_out(), g % 16);
      end
      bus.done = 1'b1;
      cyc();
      n_checks++;
      if (cur_obs() !== model_out() || bus.busy !== 1'b0 || bus.grant !== 16'h0) begin
        n_errors++; $display("FAIL rotation_idle_%0d: got %h expected %h", g, cur_obs(), model_out());
      end
    end
    bus.done = 1'b0;
  endtask

  task automatic test_skip();
    int exp_w[3] = '{15, 0, 2};
    do_reset();
    bus.req = 16'h0004;
    cyc();
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    bus.req  = 16'h8005;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (cur_obs() !== model_out() || bus.sel !== 4'(exp_w[i])) begin
        n_errors++; $display("FAIL skip_grant_%0d: got %h expected %h sel %0d", i, cur_obs(), model_out(), exp_w[i]);
      end
      bus.done = 1'b1;
      cyc();
      bus.done = 1'b0;
    end
    bus.req = 16'h0;
  endtask

  task automatic test_hold();
    bus.req = 16'h0010;
    cyc();
    bus.req = 16'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (cur_obs() !== model_out() || bus.grant !== 16'h0010 || bus.sel !== 4'd4) begin
        n_errors++; $display("FAIL hold_owner_drop_%0d: got %h expected %h", i, cur_obs(), model_out());
      end
    end
    bus.done = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (cur_obs() !== model_out() || bus.busy !== 1'b0 || bus.sel !== 4'd4) begin
        n_errors++; $display("FAIL hold_idle_done_%0d: got %h expected %h", i, cur_obs(), model_out());
      end
    end
    bus.done = 1'b0;
    bus.req  = 16'hFFFF;
    cyc();
    n_checks++;
    if (cur_obs() !== model_out() || bus.sel !== 4'd5) begin
      n_errors++; $display("FAIL hold_ptr_after: got %h expected %h", cur_obs(), model_out());
    end
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    bus.req  = 16'h0;
  endtask

  task automatic test_same_cycle();
    bus.req = 16'h0008;
    cyc();
    bus.done = 1'b1;
    bus.req  = 16'h0010;
    cyc();
    n_checks++;
    if (cur_obs() !== model_out() || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL same_cycle_idle: got %h expected %h", cur_obs(), model_out());
    end
    bus.done = 1'b0;
    cyc();
    n_checks++;
    if (cur_obs() !== model_out() || bus.sel !== 4'd4 || bus.grant !== 16'h0010) begin
      n_errors++; $display("FAIL same_cycle_grant4: got %h expected %h", cur_obs(), model_out());
    end
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    bus.req  = 16'h0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.req  = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) & 16'($urandom));
      bus.done = ($urandom_range(0, 3) == 0);
      cyc();
      n_checks++;
      if (cur_obs() !== model_out()) begin
        n_errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, cur_obs(), model_out());
      end
    end
    bus.done = 1'b0;
    bus.req  = 16'h0;
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    logic [5:0] busy_pat;
    logic [5:0] terr_pat;
    do_reset();
    bus.req = 16'h0003;
    for (int i = 0; i < 6; i++) begin
      cyc();
      busy_pat[i] = bus.busy;
      terr_pat[i] = bus.timeout_err;
      n_checks++;
      if (cur_obs() !== model_out()) begin
        n_errors++; $display("FAIL timeout_cycle_%0d: got %h expected %h", i, cur_obs(), model_out());
      end
    end
    n_checks++;
    if (busy_pat !== 6'b101111 || terr_pat !== 6'b010000 || bus.sel !== 4'd1) begin
      n_errors++; $display("FAIL timeout_release: busy %b terr %b sel %0d expected 101111 010000 1", busy_pat, terr_pat, bus.sel);
    end
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
`else
    int bad;
    bad = 0;
    do_reset();
    bus.req = 16'h0001;
    cyc();
    for (int i = 0; i < 1000; i++) begin
      bus.req = 16'($urandom);
      cyc();
      if (bus.grant !== 16'h0001 || bus.timeout_err !== 1'b0 || cur_obs() !== model_out()) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL no_timeout_hold: %0d bad cycles, required 0", bad);
    end
`endif
    bus.req = 16'h0;
  endtask

  initial begin
    bus.req  = 16'h0;
    bus.done = 1'b0;
    test_reset();
    test_rotation();
    test_skip();
    test_hold();
    test_same_cycle();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
